// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage and flag logic.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_OP_W  = 3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // One buffered result at the default datapath width.
    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [ALU_OP_W-1:0]  op;
        logic                 zero;
        logic                 neg;
        logic                 ovf;
    } entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream (ALU select) and downstream (write-back) handshake of the result stage.
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OP_W  = ALU_OP_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [OP_W-1:0]  in_op;
    logic             in_ovf;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [OP_W-1:0]  out_op;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;

    // Producer of results and consumer of the buffered stream (ALU + write-back side).
    modport master (
        output in_valid, in_result, in_op, in_ovf, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_ovf
    );

    // The result stage itself.
    modport slave (
        input  in_valid, in_result, in_op, in_ovf, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_ovf
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative/overflow flags for an ALU result.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OP_W  = ALU_OP_W
) (
    input  logic [WIDTH-1:0] in_result,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_ovf,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    // Overflow is only meaningful for ADD/SUB; SLT and logical ops never flag it.
    always_comb begin
        zero = ~|in_result;
        neg  = in_result[WIDTH-1];
        ovf  = in_ovf & ((in_op == OP_W'(OP_ADD)) | (in_op == OP_W'(OP_SUB)));
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: flag capture plus a two-entry skid buffer.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OP_W  = ALU_OP_W
) (
    input logic               clk,
    input logic               reset,
    alu_result_stage_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [OP_W-1:0]  op;
        logic             zero;
        logic             neg;
        logic             ovf;
    } stage_entry_t;

    state_e       state_q, state_d;
    stage_entry_t main_q, skid_q, in_entry;
    logic         in_ready_q;
    logic         push, pop;
    logic         load_main_in, load_main_skid, load_skid;
    logic         flag_zero, flag_neg, flag_ovf;

    alu_flag_gen #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_flag_gen (
        .in_result (bus.in_result),
        .in_op     (bus.in_op),
        .in_ovf    (bus.in_ovf),
        .zero      (flag_zero),
        .neg       (flag_neg),
        .ovf       (flag_ovf)
    );

    // Assemble the incoming entry with its flags.
    always_comb begin
        in_entry.result = bus.in_result;
        in_entry.op     = bus.in_op;
        in_entry.zero   = flag_zero;
        in_entry.neg    = flag_neg;
        in_entry.ovf    = flag_ovf;
    end

    // Handshake decode; in_ready_q is already low in FULL so push cannot occur there.
    always_comb begin
        push = bus.in_valid & in_ready_q;
        pop  = (state_q != ST_EMPTY) & bus.out_ready;
    end

    // Next state and register load selects.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    load_main_in = 1'b1;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, main entry and registered in_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
        end
    end

    // Skid entry; contents are irrelevant unless the state says FULL.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q <= in_entry;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        bus.in_ready   = in_ready_q;
        bus.out_valid  = (state_q != ST_EMPTY);
        bus.out_result = main_q.result;
        bus.out_op     = main_q.op;
        bus.out_zero   = main_q.zero;
        bus.out_neg    = main_q.neg;
        bus.out_ovf    = main_q.ovf;
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a short random scoreboard phase.
module tb_alu_result_stage;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_result_stage_if #(.WIDTH(32), .OP_W(3)) bus ();

    alu_result_stage #(
        .WIDTH (32),
        .OP_W  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_flags(input logic [31:0] r, input logic [2:0] op,
                                             input logic raw);
        logic o;
        o = raw & ((op == 3'b010) | (op == 3'b110));
        return {(r == 32'd0), r[31], o};
    endfunction

    function automatic logic [39:0] pack_out();
        return {bus.in_ready, bus.out_valid, bus.out_result, bus.out_op,
                bus.out_zero, bus.out_neg, bus.out_ovf};
    endfunction

    logic [31:0] v_res [6];
    logic [2:0]  v_op  [6];
    logic        v_ovf [6];
    logic [39:0] q_ent [$];
    logic        rdy_exp;
    logic        do_push, do_pop;
    logic [39:0] ent;

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_op     = '0;
        bus.in_ovf    = 1'b0;
        bus.out_ready = 1'b0;

        // Outputs during reset.
        step();
        step();
        chk("reset_all", 64'(pack_out()), 64'd0);

        reset = 1'b0;
        chk("rel_ready_low", 64'(bus.in_ready), 64'd0);
        step();
        chk("rel_ready_high", 64'(bus.in_ready), 64'd1);
        chk("rel_valid_low", 64'(bus.out_valid), 64'd0);

        // Directed op/flag vectors, streamed back to back with out_ready=1.
        v_res[0] = 32'h0000_0000; v_op[0] = 3'b000; v_ovf[0] = 1'b0;
        v_res[1] = 32'h8000_0000; v_op[1] = 3'b010; v_ovf[1] = 1'b1;
        v_res[2] = 32'h8000_0000; v_op[2] = 3'b001; v_ovf[2] = 1'b1;
        v_res[3] = 32'h7FFF_FFFF; v_op[3] = 3'b110; v_ovf[3] = 1'b1;
        v_res[4] = 32'h0000_0001; v_op[4] = 3'b111; v_ovf[4] = 1'b1;
        v_res[5] = 32'hFFFF_FFFF; v_op[5] = 3'b011; v_ovf[5] = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = v_res[i];
            bus.in_op     = v_op[i];
            bus.in_ovf    = v_ovf[i];
            step();
            chk($sformatf("vec%0d", i), 64'(pack_out()),
                64'({1'b1, 1'b1, v_res[i], v_op[i], exp_flags(v_res[i], v_op[i], v_ovf[i])}));
        end
        // Explicit hand-computed flags for the key vectors.
        bus.in_result = 32'h8000_0000; bus.in_op = 3'b010; bus.in_ovf = 1'b1;
        step();
        chk("add_neg_ovf", 64'({bus.out_zero, bus.out_neg, bus.out_ovf}), 64'b011);
        bus.in_result = 32'h8000_0000; bus.in_op = 3'b001; bus.in_ovf = 1'b1;
        step();
        chk("or_neg_noovf", 64'({bus.out_zero, bus.out_neg, bus.out_ovf}), 64'b010);
        bus.in_valid = 1'b0;
        step();
        chk("drain_empty", 64'(bus.out_valid), 64'd0);

        // Back-pressure: fill main and skid, third push must wait.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_op = 3'b000; bus.in_ovf = 1'b0;
        bus.in_result = 32'h11;
        step();
        chk("bp_ready_after_11", 64'(bus.in_ready), 64'd1);
        bus.in_result = 32'h22;
        step();
        chk("bp_ready_after_22", 64'(bus.in_ready), 64'd0);
        bus.in_result = 32'h33;
        step();
        chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_11", 64'({bus.out_valid, bus.out_result}), 64'({1'b1, 32'h11}));
        step();
        chk("bp_stable_11", 64'({bus.out_valid, bus.out_result}), 64'({1'b1, 32'h11}));
        bus.out_ready = 1'b1;
        step();
        chk("bp_out_22", 64'({bus.out_valid, bus.out_result}), 64'({1'b1, 32'h22}));
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        step();
        chk("bp_out_33", 64'({bus.out_valid, bus.out_result}), 64'({1'b1, 32'h33}));
        bus.in_valid = 1'b0;
        step();
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // Sustained streaming: one result per cycle, one-cycle latency.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in_result = 32'(i + 256);
            step();
            chk($sformatf("stream%0d", i), 64'({bus.in_ready, bus.out_valid, bus.out_result}),
                64'({1'b1, 1'b1, 32'(i + 256)}));
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_empty", 64'(bus.out_valid), 64'd0);

        // Reset while FULL discards both entries.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'hAA;
        step();
        bus.in_result = 32'hBB;
        step();
        chk("full_before_rst", 64'({bus.in_ready, bus.out_valid, bus.out_result}),
            64'({1'b0, 1'b1, 32'hAA}));
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        step();
        chk("rst_full_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_full_ready", 64'(bus.in_ready), 64'd0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_rst_empty%0d", i), 64'(bus.out_valid), 64'd0);
            step();
        end

        // Random traffic against a queue model.
        rdy_exp = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_result = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            bus.in_op     = 3'($urandom_range(0, 7));
            bus.in_ovf    = 1'($urandom_range(0, 1));
            if (q_ent.size() == 0) begin
                chk($sformatf("rnd%0d_idle", c), 64'({bus.in_ready, bus.out_valid}),
                    64'({rdy_exp, 1'b0}));
            end else begin
                chk($sformatf("rnd%0d", c), 64'(pack_out()),
                    64'({rdy_exp, 1'b1, q_ent[0][37:0]}));
            end
            do_push = bus.in_valid & rdy_exp;
            do_pop  = (q_ent.size() != 0) & bus.out_ready;
            ent = {2'b00, bus.in_result, bus.in_op,
                   exp_flags(bus.in_result, bus.in_op, bus.in_ovf)};
            step();
            if (do_pop) void'(q_ent.pop_front());
            if (do_push) q_ent.push_back(ent);
            rdy_exp = (q_ent.size() < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
